// File: rtl/ring_pkg.sv
// ring_pkg: shared types and widths for the RingBuffer read-side client.
package ring_pkg;
   typedef enum logic [1:0] {IDLE, REQ, WAIT, PRESENT} state_t;
   localparam int RING_DATA_W = 8;
   localparam int WORD_W = 32;
endpackage

// File: rtl/ring_word_reader_if.sv
// ring_word_reader_if: RingBuffer read port plus downstream word handshake.
interface ring_word_reader_if;
   import ring_pkg::*;
   logic readEnable;
   logic dataReadAck;
   logic [RING_DATA_W-1:0] dataRead;
   logic [WORD_W-1:0] wordData;
   logic wordValid;
   logic wordReady;
   modport master (
      output readEnable, wordData, wordValid,
      input  dataReadAck, dataRead, wordReady
   );
   modport slave (
      input  readEnable, wordData, wordValid,
      output dataReadAck, dataRead, wordReady
   );
endinterface

// File: rtl/ring_word_lane_pack.sv
// ring_word_lane_pack: steers the next byte into its word lane.
module ring_word_lane_pack
   import ring_pkg::*;
#(
   parameter int WORD_BYTES = 4,
   parameter bit BIG_ENDIAN = 1'b0
) (
   input  logic [1:0]             byte_count,
   input  logic [RING_DATA_W-1:0] data_read,
   output logic [3:0]             lane_we,
   output logic [WORD_W-1:0]      lane_data
);
   logic [1:0] lane;
   // Big-endian mirrors within the used lanes only, so upper lanes stay zero.
   assign lane = BIG_ENDIAN ? 2'(WORD_BYTES - 1) - byte_count : byte_count;
   assign lane_we = 4'b0001 << lane;
   assign lane_data = WORD_W'(data_read) << {lane, 3'b000};
endmodule

// File: rtl/ring_word_reader.sv
// ring_word_reader: drains RingBuffer bytes one request at a time and
// presents packed words over a valid/ready handshake.
module ring_word_reader
   import ring_pkg::*;
#(
   parameter int WORD_BYTES = 4,
   parameter bit BIG_ENDIAN = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic flush,
   ring_word_reader_if.master bus,
   output logic [WORD_W-1:0] debug
);
   state_t state;
   state_t next_run;
   logic [7:0] byte_count;
   logic [15:0] empty_polls;
   logic [3:0] lane_we;
   logic [WORD_W-1:0] lane_data;
   logic [WORD_W-1:0] lane_bits;
   logic last_byte;

   ring_word_lane_pack #(.WORD_BYTES(WORD_BYTES), .BIG_ENDIAN(BIG_ENDIAN)) u_pack (
      .byte_count(byte_count[1:0]),
      .data_read(bus.dataRead),
      .lane_we(lane_we),
      .lane_data(lane_data)
   );

   assign lane_bits = {{8{lane_we[3]}}, {8{lane_we[2]}}, {8{lane_we[1]}}, {8{lane_we[0]}}};
   assign last_byte = byte_count == 8'(WORD_BYTES - 1);
   assign next_run = enable ? REQ : IDLE;
   assign bus.readEnable = state == REQ;
   assign bus.wordValid = state == PRESENT;
   assign debug = {state, 6'b0, byte_count, empty_polls};

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         byte_count <= '0;
         empty_polls <= '0;
         bus.wordData <= '0;
      end else if (flush) begin
         state <= next_run;
         byte_count <= '0;
         bus.wordData <= '0;
      end else begin
         case (state)
            IDLE: state <= next_run;
            REQ: state <= WAIT;
            WAIT: begin
               if (bus.dataReadAck) begin
                  bus.wordData <= (bus.wordData & ~lane_bits) | lane_data;
                  byte_count <= last_byte ? 8'd0 : byte_count + 8'd1;
                  state <= last_byte ? PRESENT : next_run;
               end else begin
                  empty_polls <= empty_polls + 16'(empty_polls != 16'hFFFF);
                  state <= next_run;
               end
            end
            default: begin
               // Clearing on transfer gives the next word zeroed unfilled lanes.
               if (bus.wordReady) begin
                  state <= next_run;
                  bus.wordData <= '0;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ring_word_reader.sv
// tb_ring_word_reader: directed and random checks of two reader configurations
// against a queue-based RingBuffer and word-packing model.
module tb_ring_word_reader;
   import ring_pkg::*;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic enable = 1'b0;
   logic flush = 1'b0;
   logic stray0 = 1'b0;
   logic [31:0] debug0, debug1, e0, e1;
   logic [7:0] t0, t1;
   logic [8:0] re_pat, v_pat;
   logic [7:0] q0[$], q1[$], sb0[$], sb1[$];
   int n_checks = 0;
   int n_fail = 0;
   int words0 = 0;

   ring_word_reader_if b0();
   ring_word_reader_if b1();

   ring_word_reader #(.WORD_BYTES(4), .BIG_ENDIAN(1'b0)) dut0 (
      .clk(clk), .reset(reset), .enable(enable), .flush(flush), .bus(b0), .debug(debug0));
   ring_word_reader #(.WORD_BYTES(2), .BIG_ENDIAN(1'b1)) dut1 (
      .clk(clk), .reset(reset), .enable(enable), .flush(flush), .bus(b1), .debug(debug1));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // RingBuffer: a request sampled at one edge is answered during the next cycle.
   always @(posedge clk) begin
      if (b0.readEnable === 1'b1 && q0.size() > 0) begin
         t0 = q0.pop_front();
         b0.dataReadAck <= 1'b1;
         b0.dataRead <= t0;
      end else begin
         b0.dataReadAck <= stray0;
         b0.dataRead <= 8'hEE;
      end
      if (b1.readEnable === 1'b1 && q1.size() > 0) begin
         t1 = q1.pop_front();
         b1.dataReadAck <= 1'b1;
         b1.dataRead <= t1;
      end else begin
         b1.dataReadAck <= 1'b0;
         b1.dataRead <= 8'hEE;
      end
   end

   // Every transferred word must be the next bytes of the stream, packed by byte order.
   always @(negedge clk) begin
      if (!reset && !flush && b0.wordValid && b0.wordReady) begin
         if (sb0.size() < 4) check("word0_underflow", 32'(sb0.size()), 32'd4);
         else begin
            e0 = '0;
            for (int i = 0; i < 4; i++) e0 |= 32'(sb0.pop_front()) << (8 * i);
            check("word0", b0.wordData, e0);
            words0++;
         end
      end
      if (!reset && !flush && b1.wordValid && b1.wordReady) begin
         if (sb1.size() < 2) check("word1_underflow", 32'(sb1.size()), 32'd2);
         else begin
            e1 = '0;
            for (int i = 0; i < 2; i++) e1 |= 32'(sb1.pop_front()) << (8 * (1 - i));
            check("word1", b1.wordData, e1);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push0(input logic [7:0] b);
      q0.push_back(b);
      sb0.push_back(b);
   endtask

   task automatic wait_valid(input bit sel, input int max, input string tag);
      int i = 0;
      while (!(sel ? b1.wordValid : b0.wordValid) && i < max) begin
         tick();
         i++;
      end
      check(tag, 32'(sel ? b1.wordValid : b0.wordValid), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired before summary");
      $fatal(1);
   end

   initial begin
      int i, n, cnt, w_start;
      bit vseen;
      b0.wordReady = 1'b0;
      b1.wordReady = 1'b0;
      tick();
      tick();
      check("reset_debug", debug0, 32'd0);
      check("reset_valid", 32'(b0.wordValid), 32'd0);
      check("reset_data", b0.wordData, 32'd0);
      check("reset_re", 32'(b0.readEnable), 32'd0);
      reset = 1'b0;
      tick();
      // Four bytes, word ready immediately
      push0(8'h11); push0(8'h22); push0(8'h33); push0(8'h44);
      b0.wordReady = 1'b1;
      enable = 1'b1;
      i = 0;
      while (!b0.readEnable && i < 5) begin tick(); i++; end
      re_pat = '0;
      v_pat = '0;
      for (int c = 0; c < 9; c++) begin
         re_pat[c] = b0.readEnable;
         v_pat[c] = b0.wordValid;
         if (c == 8) check("t1_data", b0.wordData, 32'h44332211);
         if (c < 8) tick();
      end
      check("t1_re_pattern", 32'(re_pat), 32'b001010101);
      check("t1_valid_pattern", 32'(v_pat), 32'b100000000);
      tick();
      check("t1_valid_drop", 32'(b0.wordValid), 32'd0);
      check("t1_polls0", 32'(debug0[15:0]), 32'd0);
      tick();
      tick();
      check("t1_polls1", 32'(debug0[15:0]), 32'd1);
      // Empty buffer polling
      enable = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      enable = 1'b1;
      cnt = 0;
      vseen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick();
         cnt += int'(b0.readEnable);
         vseen |= b0.wordValid;
      end
      enable = 1'b0;
      tick();
      check("t2_re_pulses", 32'(cnt), 32'd10);
      check("t2_polls", 32'(debug0[15:0]), 32'd10);
      check("t2_no_valid", 32'(vseen), 32'd0);
      // Backpressure
      b0.wordReady = 1'b0;
      for (int b = 1; b <= 7; b++) push0(8'(b));
      enable = 1'b1;
      wait_valid(0, 30, "t3_valid1");
      check("t3_data1", b0.wordData, 32'h04030201);
      push0(8'h08);
      for (int c = 0; c < 4; c++) begin
         tick();
         check("t3_hold_valid", 32'(b0.wordValid), 32'd1);
         check("t3_hold_data", b0.wordData, 32'h04030201);
         check("t3_hold_re", 32'(b0.readEnable), 32'd0);
      end
      check("t3_buffer_level", 32'(q0.size()), 32'd4);
      b0.wordReady = 1'b1;
      tick();
      check("t3_valid_drop", 32'(b0.wordValid), 32'd0);
      wait_valid(0, 20, "t3_valid2");
      check("t3_data2", b0.wordData, 32'h08070605);
      enable = 1'b0;
      tick();
      tick();
      // Flush mid-word
      push0(8'hAA); push0(8'hBB);
      enable = 1'b1;
      n = 0;
      i = 0;
      while (n < 2 && i < 20) begin tick(); n += int'(b0.dataReadAck); i++; end
      check("t4_acks", 32'(n), 32'd2);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      sb0.delete();
      check("t4_flush_data", b0.wordData, 32'd0);
      check("t4_flush_count", 32'(debug0[23:16]), 32'd0);
      check("t4_flush_valid", 32'(b0.wordValid), 32'd0);
      push0(8'hA1); push0(8'hA2); push0(8'hA3); push0(8'hA4);
      wait_valid(0, 30, "t4_valid");
      check("t4_data", b0.wordData, 32'hA4A3A2A1);
      enable = 1'b0;
      tick();
      tick();
      // Reset while a byte is being acked, then a stray ack
      push0(8'h55); push0(8'h66);
      enable = 1'b1;
      i = 0;
      while (!b0.dataReadAck && i < 10) begin tick(); i++; end
      check("t5_ack", 32'(b0.dataReadAck), 32'd1);
      reset = 1'b1;
      stray0 = 1'b1;
      tick();
      reset = 1'b0;
      stray0 = 1'b0;
      check("t5_valid", 32'(b0.wordValid), 32'd0);
      check("t5_data", b0.wordData, 32'd0);
      check("t5_re", 32'(b0.readEnable), 32'd0);
      check("t5_debug", debug0, 32'd0);
      tick();
      check("t5_re_after", 32'(b0.readEnable), 32'd1);
      sb0.delete();
      sb0.push_back(8'h66);
      push0(8'h77); push0(8'h88); push0(8'h99);
      wait_valid(0, 30, "t5_valid2");
      check("t5_data2", b0.wordData, 32'h99887766);
      enable = 1'b0;
      tick();
      tick();
      // Big-endian two-byte words
      b1.wordReady = 1'b1;
      q1.push_back(8'h12); sb1.push_back(8'h12);
      q1.push_back(8'h34); sb1.push_back(8'h34);
      enable = 1'b1;
      wait_valid(1, 20, "t6_valid");
      check("t6_data", b1.wordData, 32'h00001234);
      enable = 1'b0;
      tick();
      tick();
      // Random traffic against the stream model
      w_start = words0;
      repeat (400) begin
         if ($urandom_range(0, 2) == 0 && q0.size() < 7) push0(8'($urandom));
         b0.wordReady = $urandom_range(0, 3) != 0;
         enable = $urandom_range(0, 7) != 0;
         tick();
      end
      enable = 1'b1;
      b0.wordReady = 1'b1;
      i = 0;
      while ((sb0.size() >= 4 || b0.wordValid) && i < 100) begin tick(); i++; end
      tick();
      tick();
      check("rand_drained", 32'(sb0.size() < 4), 32'd1);
      check("rand_words", 32'(words0 > w_start), 32'd1);
      check("rand_partial", 32'(debug0[23:16]), 32'(sb0.size()));
      enable = 1'b0;
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
